sisc_ctrl: RTL and testbench

Multi-cycle control unit for the SISC processor. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath enable and every 2:1 mux select (register-read select, writeback select, branch-target select, PC select, memory-address select) from a single state register and the instruction fields. Sits beside the datapath, between the IR/status register and the register file, ALU, PC and memories.

---
 rtl/sisc_pkg.sv | 40 ++++
 rtl/sisc_br_cond.sv | 17 +
 rtl/sisc_ctrl.sv | 155 +++++++++++++++
 tb/tb_sisc_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control path: opcodes, FSM states, ALU modes, status bits.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sisc_pkg;

   // Default field widths; the control unit takes them as parameters with these values.
   localparam int OPC_DEF_W  = 4;
   localparam int MM_DEF_W   = 4;
   localparam int STAT_DEF_W = 4;

   // Opcodes (instr[31:28]); anything not listed is executed as a NOP.
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ALU = 4'b0001;
   localparam logic [3:0] OP_LOD = 4'b0010;
   localparam logic [3:0] OP_STR = 4'b0011;
   localparam logic [3:0] OP_BRA = 4'b0100;
   localparam logic [3:0] OP_BRR = 4'b0101;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Binary-encoded FSM states.
   localparam logic [2:0] S_START     = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEM       = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_HALT      = 3'd6;

   // ALU operation select; 2'b11 is reserved and never driven.
   localparam logic [1:0] ALU_IDLE = 2'b00;
   localparam logic [1:0] ALU_FUNC = 2'b01;
   localparam logic [1:0] ALU_ADDR = 2'b10;

   // Status register bit positions, order {C,V,N,Z}.
   localparam int STAT_Z = 0;
   localparam int STAT_N = 1;
   localparam int STAT_V = 2;
   localparam int STAT_C = 3;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition: taken when the mode mask is zero (unconditional) or selects any set flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module sisc_br_cond #(
   parameter int W = 4
) (
   input  logic [W-1:0] mm,
   input  logic [W-1:0] stat,
   output logic         taken
);

   // A zero mask means "always"; otherwise any masked flag that is set fires the branch.
   always_comb begin
      taken = (mm == '0) || ((mm & stat) != '0);
   end

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control unit: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
// Latency: 5 cycles FETCH to FETCH per instruction; HLT reaches HALT 2 cycles after FETCH.
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
module sisc_ctrl
   import sisc_pkg::*;
#(
   parameter int OPC_W  = OPC_DEF_W,
   parameter int MM_W   = MM_DEF_W,
   parameter int STAT_W = STAT_DEF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [MM_W-1:0]   mm,
   input  logic [STAT_W-1:0] stat,
   output logic              ir_load,
   output logic              pc_rst,
   output logic              pc_write,
   output logic              pc_sel,
   output logic              br_sel,
   output logic              rb_sel,
   output logic [1:0]        alu_op,
   output logic              stat_en,
   output logic              mm_sel,
   output logic              dm_we,
   output logic              wb_sel,
   output logic              rf_we,
   output logic              halted
);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       br_taken;

   logic is_alu;
   logic is_lod;
   logic is_str;
   logic is_bra;
   logic is_brr;
   logic is_hlt;

   // Opcode decode; undefined opcodes match nothing and so fall through as NOPs.
   always_comb begin
      is_alu = (opcode == OPC_W'(OP_ALU));
      is_lod = (opcode == OPC_W'(OP_LOD));
      is_str = (opcode == OPC_W'(OP_STR));
      is_bra = (opcode == OPC_W'(OP_BRA));
      is_brr = (opcode == OPC_W'(OP_BRR));
      is_hlt = (opcode == OPC_W'(OP_HLT));
   end

   // The mode field is compared bitwise against the status flags, so both share one width.
   sisc_br_cond #(
      .W (MM_W)
   ) u_br_cond (
      .mm    (mm),
      .stat  (MM_W'(stat)),
      .taken (br_taken)
   );

   // State register; reset wins over every transition, including leaving HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_START;
      end else begin
         state <= state_nxt;
      end
   end

   // Fixed step sequence; only DECODE branches (to HALT on HLT).
   always_comb begin
      state_nxt = S_START;
      case (state)
         S_START:     state_nxt = S_FETCH;
         S_FETCH:     state_nxt = S_DECODE;
         S_DECODE:    state_nxt = is_hlt ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_nxt = S_MEM;
         S_MEM:       state_nxt = S_WRITEBACK;
         S_WRITEBACK: state_nxt = S_FETCH;
         S_HALT:      state_nxt = S_HALT;
         default:     state_nxt = S_START;
      endcase
   end

   // Datapath controls: everything defaults low, each state raises only what it uses.
   always_comb begin
      ir_load  = 1'b0;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      rb_sel   = 1'b0;
      alu_op   = ALU_IDLE;
      stat_en  = 1'b0;
      mm_sel   = 1'b0;
      dm_we    = 1'b0;
      wb_sel   = 1'b0;
      rf_we    = 1'b0;
      halted   = 1'b0;
      case (state)
         S_START: begin
            pc_rst = 1'b1;
         end
         S_FETCH: begin
            // Memory is addressed by PC and PC advances, so branch targets see PC+1.
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            // A store reads rd on port B to supply the write data.
            rb_sel = is_str;
            // The branch resolves here: stat as seen at the closing edge picks the PC.
            if ((is_bra || is_brr) && br_taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = is_bra;
            end
         end
         S_EXECUTE: begin
            if (is_alu) begin
               alu_op  = ALU_FUNC;
               stat_en = 1'b1;
            end else if (is_lod || is_str) begin
               alu_op = ALU_ADDR;
            end
         end
         S_MEM: begin
            if (is_str) begin
               mm_sel = 1'b1;
               dm_we  = 1'b1;
            end else if (is_lod) begin
               mm_sel = 1'b1;
               rb_sel = 1'b1;
            end
         end
         S_WRITEBACK: begin
            // ALU result and load address are held so the written value stays stable.
            if (is_alu) begin
               rf_we  = 1'b1;
               alu_op = ALU_FUNC;
            end else if (is_lod) begin
               rf_we  = 1'b1;
               wb_sel = 1'b1;
               mm_sel = 1'b1;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Directed bench for sisc_ctrl: one table of per-cycle vectors plus hand-written corner sequences.
// Latency: checks 5-cycle instruction spacing and 2-cycle FETCH-to-HALT.
// Backpressure: n/a.
module tb_sisc_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] opcode;
   logic [3:0] mm;
   logic [3:0] stat;
   logic       ir_load;
   logic       pc_rst;
   logic       pc_write;
   logic       pc_sel;
   logic       br_sel;
   logic       rb_sel;
   logic [1:0] alu_op;
   logic       stat_en;
   logic       mm_sel;
   logic       dm_we;
   logic       wb_sel;
   logic       rf_we;
   logic       halted;

   int errors = 0;
   int checks = 0;

   // Output vector bit masks:
   // {ir_load,pc_rst,pc_write,pc_sel,br_sel,rb_sel,alu_op[1:0],stat_en,mm_sel,dm_we,wb_sel,rf_we,halted}
   localparam logic [13:0] NONE = 14'h0000;
   localparam logic [13:0] IR   = 14'h2000;
   localparam logic [13:0] PR   = 14'h1000;
   localparam logic [13:0] PW   = 14'h0800;
   localparam logic [13:0] PS   = 14'h0400;
   localparam logic [13:0] BS   = 14'h0200;
   localparam logic [13:0] RB   = 14'h0100;
   localparam logic [13:0] AA   = 14'h0080;
   localparam logic [13:0] AF   = 14'h0040;
   localparam logic [13:0] SE   = 14'h0020;
   localparam logic [13:0] MS   = 14'h0010;
   localparam logic [13:0] DW   = 14'h0008;
   localparam logic [13:0] WS   = 14'h0004;
   localparam logic [13:0] RW   = 14'h0002;
   localparam logic [13:0] HL   = 14'h0001;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  opcode;
      logic [3:0]  mm;
      logic [3:0]  stat;
      logic [13:0] exp;
   } vec_t;

   vec_t vq[$];

   sisc_ctrl #(
      .OPC_W  (4),
      .MM_W   (4),
      .STAT_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .mm       (mm),
      .stat     (stat),
      .ir_load  (ir_load),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .rb_sel   (rb_sel),
      .alu_op   (alu_op),
      .stat_en  (stat_en),
      .mm_sel   (mm_sel),
      .dm_we    (dm_we),
      .wb_sel   (wb_sel),
      .rf_we    (rf_we),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input string n, input logic r, input logic [3:0] op,
                      input logic [3:0] m, input logic [3:0] s, input logic [13:0] e);
      vec_t v;
      v.name   = n;
      v.rst    = r;
      v.opcode = op;
      v.mm     = m;
      v.stat   = s;
      v.exp    = e;
      vq.push_back(v);
   endtask

   task automatic check(input string n, input logic [13:0] e);
      logic [13:0] act;
      act = {ir_load, pc_rst, pc_write, pc_sel, br_sel, rb_sel, alu_op,
             stat_en, mm_sel, dm_we, wb_sel, rf_we, halted};
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %b expected %b", n, act, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 4'h0;
      mm     = 4'h0;
      stat   = 4'h0;

      // One entry per cycle; outputs are checked before the edge that consumes the entry.
      add("rst_hold_start", 1'b1, 4'h0, 4'h0, 4'h0, PR);
      add("rst_rel_start",  1'b0, 4'h0, 4'h0, 4'h0, PR);
      add("alu_fetch",      1'b0, 4'h1, 4'h0, 4'h0, IR | PW);
      add("alu_decode",     1'b0, 4'h1, 4'h0, 4'h0, NONE);
      add("alu_execute",    1'b0, 4'h1, 4'h0, 4'h0, AF | SE);
      add("alu_mem",        1'b0, 4'h1, 4'h0, 4'h0, NONE);
      add("alu_wb",         1'b0, 4'h1, 4'h0, 4'h0, RW | AF);
      add("lod_fetch",      1'b0, 4'h2, 4'h0, 4'h0, IR | PW);
      add("lod_decode",     1'b0, 4'h2, 4'h0, 4'h0, NONE);
      add("lod_execute",    1'b0, 4'h2, 4'h0, 4'h0, AA);
      add("lod_mem",        1'b0, 4'h2, 4'h0, 4'h0, MS | RB);
      add("lod_wb",         1'b0, 4'h2, 4'h0, 4'h0, RW | WS | MS);
      add("str_fetch",      1'b0, 4'h3, 4'h0, 4'h0, IR | PW);
      add("str_decode",     1'b0, 4'h3, 4'h0, 4'h0, RB);
      add("str_execute",    1'b0, 4'h3, 4'h0, 4'h0, AA);
      add("str_mem",        1'b0, 4'h3, 4'h0, 4'h0, MS | DW);
      add("str_wb",         1'b0, 4'h3, 4'h0, 4'h0, NONE);
      add("brr_t_fetch",    1'b0, 4'h5, 4'h1, 4'h1, IR | PW);
      add("brr_t_decode",   1'b0, 4'h5, 4'h1, 4'h1, PW | PS);
      add("brr_t_execute",  1'b0, 4'h5, 4'h1, 4'h1, NONE);
      add("brr_t_mem",      1'b0, 4'h5, 4'h1, 4'h1, NONE);
      add("brr_t_wb",       1'b0, 4'h5, 4'h1, 4'h1, NONE);
      add("brr_nt_fetch",   1'b0, 4'h5, 4'h1, 4'he, IR | PW);
      add("brr_nt_decode",  1'b0, 4'h5, 4'h1, 4'he, NONE);
      add("brr_nt_execute", 1'b0, 4'h5, 4'h1, 4'he, NONE);
      add("brr_nt_mem",     1'b0, 4'h5, 4'h1, 4'he, NONE);
      add("brr_nt_wb",      1'b0, 4'h5, 4'h1, 4'he, NONE);
      add("bra_fetch",      1'b0, 4'h4, 4'h0, 4'h0, IR | PW);
      add("bra_decode",     1'b0, 4'h4, 4'h0, 4'h0, PW | PS | BS);
      add("bra_execute",    1'b0, 4'h4, 4'h0, 4'h0, NONE);
      add("bra_mem",        1'b0, 4'h4, 4'h0, 4'h0, NONE);
      add("bra_wb",         1'b0, 4'h4, 4'h0, 4'h0, NONE);
      add("undef_fetch",    1'b0, 4'ha, 4'h0, 4'h0, IR | PW);
      add("undef_decode",   1'b0, 4'ha, 4'h0, 4'h0, NONE);
      add("undef_execute",  1'b0, 4'ha, 4'h0, 4'h0, NONE);
      add("undef_mem",      1'b0, 4'ha, 4'h0, 4'h0, NONE);
      add("undef_wb",       1'b0, 4'ha, 4'h0, 4'h0, NONE);
      add("hlt_fetch",      1'b0, 4'hf, 4'h0, 4'h0, IR | PW);
      add("hlt_decode",     1'b0, 4'hf, 4'h0, 4'h0, NONE);
      add("hlt_enter",      1'b0, 4'hf, 4'h0, 4'h0, HL);

      // First reset edge puts the FSM in START.
      tick();

      foreach (vq[i]) begin
         rst    = vq[i].rst;
         opcode = vq[i].opcode;
         mm     = vq[i].mm;
         stat   = vq[i].stat;
         #1;
         check(vq[i].name, vq[i].exp);
         tick();
      end

      // HALT holds for 20 more cycles regardless of IR and status.
      for (int k = 0; k < 20; k++) begin
         opcode = 4'($urandom_range(0, 15));
         mm     = 4'($urandom_range(0, 15));
         stat   = 4'($urandom_range(0, 15));
         #1;
         check("halt_hold", HL);
         tick();
      end

      // Reset takes priority over HALT and lands in START on the next edge.
      rst    = 1'b1;
      opcode = 4'h3;
      mm     = 4'h0;
      stat   = 4'h0;
      #1;
      check("halt_before_rst_edge", HL);
      tick();
      check("halt_rst_start", PR);
      rst = 1'b0;
      tick();
      check("post_halt_fetch", IR | PW);

      // Mid-instruction reset: STR in MEM must stop writing from the reset edge on.
      tick();
      check("mid_str_decode", RB);
      tick();
      check("mid_str_execute", AA);
      tick();
      check("mid_str_mem", MS | DW);
      rst = 1'b1;
      tick();
      check("mid_rst_start", PR);
      rst = 1'b0;
      tick();
      check("mid_rst_fetch", IR | PW);

      // Status moving during DECODE: the value present at the closing edge wins.
      opcode = 4'h5;
      mm     = 4'h4;
      stat   = 4'h0;
      tick();
      check("brr_stat_early", NONE);
      stat = 4'h4;
      #1;
      check("brr_stat_late", PW | PS);
      tick();
      check("brr_stat_execute", NONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
